dma_lane_unpacker: RTL and testbench
====================================

// Module: dma_lane_unpacker
// PURPOSE
//  Downstream consumer of one output lane of the 6-way DMA lane router; instantiated once per lane (x6).
//  Captures 25-bit lane words {data[23:0], en} on the DMA write strobe and queues them in a small word FIFO.
//  Serializes each queued word into three bytes on a valid/ready byte stream.
//  The byte stream feeds the lane's accelerator input buffer.
// PARAMETERS
//  DEPTH   4   word FIFO entries; power of 2, >=2. Total capacity = DEPTH + 1 word (one word in the serializer).
// PORTS
//  clk         in   1              single clock, all logic rising-edge
//  rst_n       in   1              asynchronous active-low reset
//  lane_in     in   25             routed lane word: [24:1] = data (DMA bits [31:8]), [0] = enable (DMA bit 7)
//  lane_strobe in   1              1-cycle DMA write strobe; lane_in is valid only in this cycle
//  flush       in   1              synchronous clear of FIFO, serializer and overflow flag
//  byte_data   out  8              serialized byte
//  byte_valid  out  1              byte_data valid
//  byte_ready  in   1              consumer accepts byte when byte_valid & byte_ready
//  level       out  $clog2(DEPTH)+1  words held in FIFO (excludes serializer word)
//  full        out  1              level == DEPTH
//  overflow    out  1              sticky: a qualified push was dropped
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, ptrs=0, level=0, full=0, overflow=0, byte_valid=0, byte_data=0, FSM=IDLE.
//  Push: push = lane_strobe & lane_in[0] & ~flush. Strobe with en=0 is ignored entirely (no flag change).
//   Accepted if level<DEPTH, or if a pop occurs in the same cycle (full + pop + push -> level stays DEPTH).
//   Otherwise the word is dropped and overflow is set at the next edge; FIFO content unchanged.
//  Byte order: lane_in[24:17] first (DMA [31:24]), then [16:9], then [8:1].
//  FSM states: IDLE, B0, B1, B2 (byte index currently presented).
//   IDLE: byte_valid=0; if level>0, pop the head word into the 24-bit shift reg -> B0.
//   B0/B1: byte_valid=1; on valid&ready advance to B1/B2.
//   B2: byte_valid=1; on valid&ready: if level>0, pop next word -> B0 (no bubble); else -> IDLE.
//   Without ready, state, byte_data and byte_valid are held unchanged (no withdraw, no data change).
//  Latency: strobe in cycle N into empty unit -> word in FIFO after edge N, popped at edge N+1,
//   byte_valid=1 with first byte in cycle N+2. With ready held high: 3 bytes in 3 consecutive cycles;
//   back-to-back words stream with no idle cycle.
//  Pop and push in the same cycle: level unchanged; pop reads the old head (no write-through to empty FIFO).
//  Pointers: DEPTH-entry circular buffer, $clog2(DEPTH)-bit pointers wrap naturally at DEPTH-1 -> 0.
//  Flush (sync, priority over push/pop): at next edge FIFO empty, level=0, FSM=IDLE, byte_valid=0,
//   overflow=0; a byte handshaking in the flush cycle counts as consumed; same-cycle push is dropped
//   without setting overflow.
//  Reset mid-word: all state cleared immediately and asynchronously; partial word discarded; no output
//   glitch to byte_valid=1.
//  full and level are registered, updated at the same edge as the FIFO.
// TESTING
//  T1 strobe lane_in={24'hA1B2C3,1'b1}, ready=1 -> byte_valid in cycle N+2, bytes A1,B2,C3 in 3 cycles, then valid=0.
//  T2 strobe lane_in={24'h123456,1'b0} -> no byte_valid, level stays 0, overflow stays 0.
//  T3 word 0x0A0B0C, ready=0 for 5 cycles then 1 -> byte_data=0A held stable with valid=1; then 0A,0B,0C.
//  T4 ready=0, push 6 words (DEPTH=4) -> 1 in serializer, level=4, full=1, 6th dropped, overflow=1; drain gives
//     exactly 5 words in order.
//  T5 two words strobed on consecutive cycles, ready=1 -> 6 bytes on 6 consecutive cycles, no bubble.
//  T6 flush during B1 with 2 words queued -> next cycle byte_valid=0, level=0, overflow=0; reset asserted
//     mid-word -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dma_lane_unpacker.sv
// ============================================================================
// dma_lane_unpacker : queues 24-bit DMA lane words and emits them MSB-byte
//                     first on a valid/ready byte stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_lane_unpacker #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [24:0]                lane_in_i,
  input  logic                       lane_strobe_i,
  input  logic                       flush_i,
  output logic [7:0]                 byte_data_o,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] c_ONE   = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } state_t;

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q;
  logic          overflow_q, overflow_d;

  state_t        state_q;
  logic [23:0]   shift_q;
  logic [7:0]    byte_data_q;
  logic          byte_valid_q;

  logic          w_fire;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_drop;
  logic [23:0]   w_head;

  assign w_fire     = byte_valid_q & byte_ready_i;
  assign w_head     = mem_q[rd_ptr_q];
  assign w_push_req = lane_strobe_i & lane_in_i[0] & ~flush_i;

  // Pop when the serializer is idle, or as its last byte leaves, so words stream without a bubble.
  assign w_pop = ~flush_i & (level_q != '0) &
                 ((state_q == S_IDLE) | ((state_q == S_B2) & w_fire));

  // A full FIFO still accepts a word if the head leaves in the same cycle.
  assign w_push = w_push_req & ((level_q != c_DEPTH) | w_pop);
  assign w_drop = w_push_req & ~w_push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + c_ONE;
        2'b01:   level_d = level_q - c_ONE;
        default: level_d = level_q;
      endcase
      if (w_drop) overflow_d = 1'b1;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= lane_in_i[24:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= (level_d == c_DEPTH);
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= S_IDLE;
      byte_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            shift_q      <= w_head;
            byte_data_q  <= w_head[23:16];
            byte_valid_q <= 1'b1;
            state_q      <= S_B0;
          end
        end
        S_B0: begin
          if (w_fire) begin
            byte_data_q <= shift_q[15:8];
            state_q     <= S_B1;
          end
        end
        S_B1: begin
          if (w_fire) begin
            byte_data_q <= shift_q[7:0];
            state_q     <= S_B2;
          end
        end
        S_B2: begin
          if (w_pop) begin
            shift_q     <= w_head;
            byte_data_q <= w_head[23:16];
            state_q     <= S_B0;
          end else if (w_fire) begin
            byte_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          byte_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_data_o  = byte_data_q;
  assign byte_valid_o = byte_valid_q;
  assign level_o      = level_q;
  assign full_o       = full_q;
  assign overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_lane_unpacker.sv
// ============================================================================
// tb_dma_lane_unpacker : directed self-checking bench for dma_lane_unpacker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_lane_unpacker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] lane_in;
  logic        lane_strobe;
  logic        flush;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [2:0]  level;
  logic        full;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  dma_lane_unpacker #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lane_in_i    (lane_in),
    .lane_strobe_i(lane_strobe),
    .flush_i      (flush),
    .byte_data_o  (byte_data),
    .byte_valid_o (byte_valid),
    .byte_ready_i (byte_ready),
    .level_o      (level),
    .full_o       (full),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [23:0] w, input logic en);
    lane_in     = {w, en};
    lane_strobe = 1'b1;
    tick();
    lane_strobe = 1'b0;
    lane_in     = '0;
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, byte_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, byte_data},  {24'd0, exp});
  endtask

  logic [23:0] words [5];

  initial begin
    rst_n = 1'b0; lane_in = '0; lane_strobe = 1'b0; flush = 1'b0; byte_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_data",  {24'd0, byte_data},  32'd0);
    chk("rst_level", {29'd0, level},      32'd0);
    chk("rst_full",  {31'd0, full},       32'd0);
    chk("rst_ovf",   {31'd0, overflow},   32'd0);
    rst_n = 1'b1;
    tick();

    // T1: single word, ready high: first byte two cycles after the strobe
    byte_ready = 1'b1;
    strobe(24'hA1B2C3, 1'b1);
    chk("t1_n1_valid", {31'd0, byte_valid}, 32'd0);
    chk("t1_n1_level", {29'd0, level},      32'd1);
    tick();
    chk_byte("t1_b0", 8'hA1);
    chk("t1_level_after_pop", {29'd0, level}, 32'd0);
    tick(); chk_byte("t1_b1", 8'hB2);
    tick(); chk_byte("t1_b2", 8'hC3);
    tick(); chk("t1_idle", {31'd0, byte_valid}, 32'd0);

    // T2: strobe with enable low is ignored
    strobe(24'h123456, 1'b0);
    chk("t2_level", {29'd0, level},    32'd0);
    chk("t2_ovf",   {31'd0, overflow}, 32'd0);
    tick();
    chk("t2_valid", {31'd0, byte_valid}, 32'd0);

    // T3: backpressure holds the first byte stable
    byte_ready = 1'b0;
    strobe(24'h0A0B0C, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_byte("t3_hold", 8'h0A);
      tick();
    end
    byte_ready = 1'b1;
    chk_byte("t3_b0", 8'h0A);
    tick(); chk_byte("t3_b1", 8'h0B);
    tick(); chk_byte("t3_b2", 8'h0C);
    tick(); chk("t3_idle", {31'd0, byte_valid}, 32'd0);

    // T4: fill past capacity with ready low; sixth word dropped
    byte_ready = 1'b0;
    words[0] = 24'h111111; words[1] = 24'h222222; words[2] = 24'h333333;
    words[3] = 24'h444444; words[4] = 24'h555555;
    for (int i = 0; i < 5; i++) strobe(words[i], 1'b1);
    chk("t4_ovf_before_drop", {31'd0, overflow}, 32'd0);
    strobe(24'h666666, 1'b1);
    chk("t4_level", {29'd0, level},    32'd4);
    chk("t4_full",  {31'd0, full},     32'd1);
    chk("t4_ovf",   {31'd0, overflow}, 32'd1);
    byte_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      chk_byte("t4_drain_hi", words[w][23:16]); tick();
      chk_byte("t4_drain_mid", words[w][15:8]); tick();
      chk_byte("t4_drain_lo", words[w][7:0]);
      if (w == 0) chk("t4_full_hold", {31'd0, full}, 32'd1);
      tick();
      if (w == 0) chk("t4_level_after_pop", {29'd0, level}, 32'd3);
    end
    chk("t4_idle",       {31'd0, byte_valid}, 32'd0);
    chk("t4_level_end",  {29'd0, level},      32'd0);
    chk("t4_full_end",   {31'd0, full},       32'd0);
    chk("t4_ovf_sticky", {31'd0, overflow},   32'd1);

    // T5: back-to-back words stream with no bubble
    strobe(24'hC0FFEE, 1'b1);
    strobe(24'hBADF00, 1'b1);
    chk_byte("t5_0", 8'hC0); tick();
    chk_byte("t5_1", 8'hFF); tick();
    chk_byte("t5_2", 8'hEE); tick();
    chk_byte("t5_3", 8'hBA); tick();
    chk_byte("t5_4", 8'hDF); tick();
    chk_byte("t5_5", 8'h00); tick();
    chk("t5_idle", {31'd0, byte_valid}, 32'd0);

    // T6a: flush while presenting the middle byte, two words queued
    byte_ready = 1'b0;
    strobe(24'h010203, 1'b1);
    strobe(24'h040506, 1'b1);
    strobe(24'h070809, 1'b1);
    byte_ready = 1'b1;
    chk_byte("t6_b0", 8'h01);
    tick();
    byte_ready = 1'b0;
    chk_byte("t6_b1", 8'h02);
    chk("t6_level_pre", {29'd0, level}, 32'd2);
    flush = 1'b1; byte_ready = 1'b1;
    strobe(24'h0D0E0F, 1'b1);
    flush = 1'b0; byte_ready = 1'b0;
    chk("t6_flush_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_flush_level", {29'd0, level},      32'd0);
    chk("t6_flush_ovf",   {31'd0, overflow},   32'd0);
    chk("t6_flush_full",  {31'd0, full},       32'd0);
    tick();
    chk("t6_post_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_post_level", {29'd0, level},      32'd0);

    // T6b: asynchronous reset in the middle of a word
    strobe(24'hAABBCC, 1'b1);
    strobe(24'hDDEEFF, 1'b1);
    chk_byte("t6_mid", 8'hAA);
    chk("t6_mid_level", {29'd0, level}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", {31'd0, byte_valid}, 32'd0);
    chk("t6_arst_data",  {24'd0, byte_data},  32'd0);
    chk("t6_arst_level", {29'd0, level},      32'd0);
    chk("t6_arst_full",  {31'd0, full},       32'd0);
    chk("t6_arst_ovf",   {31'd0, overflow},   32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t6_after_rst_valid", {31'd0, byte_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
